// File: rtl/cjb_risc_hmmiop_cu.sv
// rtl/cjb_risc_hmmiop_cu.sv - control unit FSM for the CJB RISC HMMIOP core
//
// Sequences FETCH/DEC/EXEC for ALU and MOV ops, FETCH/DEC/ADDR/MEM for
// LOAD/STORE (with memory-mapped I/O at 0x3FF in, 0x3FE out), FETCH/DEC/
// ADDR/JMP for conditional jumps, and parks in HLT on HALT until Reset.
//
// Ports:
//   Clock, Reset        clock, synchronous active-high reset
//   IW[7:0]             instruction word from IR {opcode, Ri, Rj}
//   SR_CNVZ[3:0]        status flags, bit 3 = C, bit 0 = Z
//   MARout[9:0]         data-memory address register
//   RST_PC LD_PC CNT_PC LD_IR          program counter / IR controls
//   LD_R0..LD_R3 LD_SR                 register file / status loads
//   LD_MABR LD_MAXR LD_MAR             address arithmetic loads
//   RW                                 1 = read, 0 = write
//   LD_IPDR LD_OPDR                    I/O data register loads
//   IB0_SEL IB1_SEL IB2_SEL ALU_FS     bus and ALU selects
//   push pop ipstksel                  hardware stack controls
//   HALT                               high while halted
//
// Build option: define CJB_CU_HWSTACK_EN to enable the 4-entry hardware
// stack (opcode 1110 PUSH/POP). Undefined, 1110 is a NOP and the stack
// controls stay low.

module cjb_risc_hmmiop_cu (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] IW,
   input  logic [3:0] SR_CNVZ,
   input  logic [9:0] MARout,
   output logic       RST_PC,
   output logic       LD_PC,
   output logic       CNT_PC,
   output logic       LD_IR,
   output logic       LD_R0,
   output logic       LD_R1,
   output logic       LD_R2,
   output logic       LD_R3,
   output logic       LD_SR,
   output logic       LD_MABR,
   output logic       LD_MAXR,
   output logic       LD_MAR,
   output logic       RW,
   output logic       LD_IPDR,
   output logic       LD_OPDR,
   output logic [1:0] IB0_SEL,
   output logic [1:0] IB1_SEL,
   output logic [1:0] IB2_SEL,
   output logic [3:0] ALU_FS,
   output logic       push,
   output logic       pop,
   output logic       ipstksel,
   output logic       HALT
);

   typedef enum logic [2:0] {
      ST_RST, ST_FETCH, ST_DEC, ST_EXEC, ST_ADDR, ST_MEM, ST_JMP, ST_HLT
   } state_t;

   localparam logic [3:0] OP_MOV   = 4'hA;
   localparam logic [3:0] OP_LOAD  = 4'hB;
   localparam logic [3:0] OP_STORE = 4'hC;
   localparam logic [3:0] OP_JUMP  = 4'hD;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t     state;
   logic [3:0] opcode;
   logic [1:0] ri;
   logic [1:0] rj;
   logic       is_alu;
   logic       jmp_taken;
   logic       ld_ri;

   assign opcode = IW[7:4];
   assign ri     = IW[3:2];
   assign rj     = IW[1:0];
   assign is_alu = (opcode >= 4'h1) && (opcode <= 4'h9);

`ifdef CJB_CU_HWSTACK_EN
   localparam logic [3:0] OP_STK = 4'hE;
   logic [2:0] depth;
   logic       stk_op;
   // Rj = 1x under opcode 1110 is reserved and treated as a NOP
   assign stk_op = (opcode == OP_STK) && !rj[1];
`endif

   // condition code in IW[3:0]; SR_CNVZ = {C, N, V, Z}
   always_comb begin
      jmp_taken = 1'b0;
      case (IW[3:0])
         4'h0:    jmp_taken = 1'b1;
         4'h1:    jmp_taken = SR_CNVZ[0];
         4'h2:    jmp_taken = !SR_CNVZ[0];
         4'h3:    jmp_taken = SR_CNVZ[3];
         4'h4:    jmp_taken = !SR_CNVZ[3];
         4'h5:    jmp_taken = SR_CNVZ[2];
         4'h6:    jmp_taken = SR_CNVZ[1];
         default: jmp_taken = 1'b0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_RST;
`ifdef CJB_CU_HWSTACK_EN
         depth <= 3'd0;
`endif
      end else begin
         case (state)
            ST_RST:   state <= ST_FETCH;
            ST_FETCH: state <= ST_DEC;
            ST_DEC: begin
               if (opcode == OP_HALT)
                  state <= ST_HLT;
               else if (is_alu || (opcode == OP_MOV))
                  state <= ST_EXEC;
               else if ((opcode == OP_LOAD) || (opcode == OP_STORE) || (opcode == OP_JUMP))
                  state <= ST_ADDR;
`ifdef CJB_CU_HWSTACK_EN
               else if (stk_op)
                  state <= ST_EXEC;
`endif
               else
                  state <= ST_FETCH;
            end
            ST_EXEC: begin
               state <= ST_FETCH;
`ifdef CJB_CU_HWSTACK_EN
               // full-stack pushes and empty-stack pops are dropped silently
               if (stk_op) begin
                  if ((rj == 2'b00) && (depth < 3'd4))
                     depth <= depth + 3'd1;
                  else if ((rj == 2'b01) && (depth != 3'd0))
                     depth <= depth - 3'd1;
               end
`endif
            end
            ST_ADDR:  state <= (opcode == OP_JUMP) ? ST_JMP : ST_MEM;
            ST_MEM:   state <= ST_FETCH;
            ST_JMP:   state <= ST_FETCH;
            ST_HLT:   state <= ST_HLT;
            default:  state <= ST_RST;
         endcase
      end
   end

   // IW is only valid once IR has loaded at the end of FETCH, so outputs are
   // decoded from the current state rather than registered a cycle early.
   always_comb begin
      RST_PC   = 1'b0;
      LD_PC    = 1'b0;
      CNT_PC   = 1'b0;
      LD_IR    = 1'b0;
      ld_ri    = 1'b0;
      LD_SR    = 1'b0;
      LD_MABR  = 1'b0;
      LD_MAXR  = 1'b0;
      LD_MAR   = 1'b0;
      RW       = 1'b1;
      LD_IPDR  = 1'b0;
      LD_OPDR  = 1'b0;
      IB0_SEL  = 2'b00;
      IB1_SEL  = 2'b00;
      IB2_SEL  = 2'b00;
      ALU_FS   = 4'h0;
      push     = 1'b0;
      pop      = 1'b0;
      ipstksel = 1'b0;
      HALT     = 1'b0;
      if (Reset) begin
         RST_PC = 1'b1;
      end else begin
         case (state)
            ST_RST: RST_PC = 1'b1;
            ST_FETCH: begin
               LD_IR  = 1'b1;
               CNT_PC = 1'b1;
            end
            ST_DEC: begin
               if ((opcode == OP_LOAD) || (opcode == OP_STORE) || (opcode == OP_JUMP)) begin
                  LD_MABR = 1'b1;
                  LD_MAXR = 1'b1;
                  CNT_PC  = 1'b1;
                  if (opcode != OP_JUMP) begin
                     IB0_SEL = rj;
                     IB2_SEL = 2'b00;
                  end
               end
            end
            ST_EXEC: begin
               if (is_alu) begin
                  ALU_FS  = opcode;
                  IB0_SEL = ri;
                  IB1_SEL = rj;
                  IB2_SEL = 2'b01;
                  ld_ri   = 1'b1;
                  LD_SR   = 1'b1;
               end else if (opcode == OP_MOV) begin
                  IB0_SEL = rj;
                  IB2_SEL = 2'b00;
                  ld_ri   = 1'b1;
               end
`ifdef CJB_CU_HWSTACK_EN
               else if (stk_op && (rj == 2'b00)) begin
                  IB0_SEL = ri;
                  IB2_SEL = 2'b00;
                  push    = (depth < 3'd4);
               end else if (stk_op) begin
                  ipstksel = 1'b1;
                  IB2_SEL  = 2'b11;
                  pop      = (depth != 3'd0);
                  ld_ri    = (depth != 3'd0);
               end
`endif
            end
            ST_ADDR: begin
               LD_MAR = 1'b1;
               if (opcode != OP_JUMP)
                  LD_IPDR = 1'b1;
            end
            ST_MEM: begin
               if (opcode == OP_LOAD) begin
                  ld_ri = 1'b1;
                  // 0x3FF reads the input port through the ipstk mux
                  IB2_SEL = (MARout == 10'h3FF) ? 2'b11 : 2'b10;
               end else begin
                  IB0_SEL = ri;
                  IB2_SEL = 2'b00;
                  // 0x3FE writes the output port instead of data memory
                  if (MARout == 10'h3FE)
                     LD_OPDR = 1'b1;
                  else
                     RW = 1'b0;
               end
            end
            ST_JMP: LD_PC = jmp_taken;
            ST_HLT: HALT = 1'b1;
            default: ;
         endcase
      end
   end

   assign LD_R0 = ld_ri && (ri == 2'd0);
   assign LD_R1 = ld_ri && (ri == 2'd1);
   assign LD_R2 = ld_ri && (ri == 2'd2);
   assign LD_R3 = ld_ri && (ri == 2'd3);

endmodule

// File: tb/tb_cjb_risc_hmmiop_cu.sv
// tb/tb_cjb_risc_hmmiop_cu.sv - self-checking bench for cjb_risc_hmmiop_cu

module tb_cjb_risc_hmmiop_cu;

   logic       Clock;
   logic       Reset;
   logic [7:0] IW;
   logic [3:0] SR_CNVZ;
   logic [9:0] MARout;
   logic RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3, LD_SR;
   logic LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR;
   logic [1:0] IB0_SEL, IB1_SEL, IB2_SEL;
   logic [3:0] ALU_FS;
   logic push, pop, ipstksel, HALT;

   cjb_risc_hmmiop_cu dut (
      .Clock(Clock), .Reset(Reset), .IW(IW), .SR_CNVZ(SR_CNVZ), .MARout(MARout),
      .RST_PC(RST_PC), .LD_PC(LD_PC), .CNT_PC(CNT_PC), .LD_IR(LD_IR),
      .LD_R0(LD_R0), .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3), .LD_SR(LD_SR),
      .LD_MABR(LD_MABR), .LD_MAXR(LD_MAXR), .LD_MAR(LD_MAR), .RW(RW),
      .LD_IPDR(LD_IPDR), .LD_OPDR(LD_OPDR),
      .IB0_SEL(IB0_SEL), .IB1_SEL(IB1_SEL), .IB2_SEL(IB2_SEL), .ALU_FS(ALU_FS),
      .push(push), .pop(pop), .ipstksel(ipstksel), .HALT(HALT)
   );

   typedef struct packed {
      logic       rst_pc, ld_pc, cnt_pc, ld_ir;
      logic [3:0] ld_r;
      logic       ld_sr, ld_mabr, ld_maxr, ld_mar, rw, ld_ipdr, ld_opdr;
      logic [1:0] ib0, ib1, ib2;
      logic [3:0] alu_fs;
      logic       push, pop, ipstksel, halt;
   } ovec_t;

   ovec_t      exp_q[$];
   ovec_t      seq[$];
   logic [1:0] stk[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         push_cnt = 0;
   int         pop_cnt = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   function automatic ovec_t idle();
      ovec_t v = '0;
      v.rw = 1'b1;
      return v;
   endfunction

   function automatic logic cond_taken(input logic [3:0] cc, input logic [3:0] sr);
      logic c, n, v, z;
      {c, n, v, z} = sr;
      case (cc)
         4'h0: return 1'b1;
         4'h1: return z;
         4'h2: return !z;
         4'h3: return c;
         4'h4: return !c;
         4'h5: return n;
         4'h6: return v;
         default: return 1'b0;
      endcase
   endfunction

   // Instruction-level model: lists the output vector of every cycle the
   // instruction occupies, starting with its fetch cycle.
   task automatic build(input logic [7:0] iw, input logic [3:0] sr, input logic [9:0] mar);
      ovec_t v;
      logic [3:0] op = iw[7:4];
      logic [1:0] ri = iw[3:2];
      logic [1:0] rj = iw[1:0];
      seq.delete();
      v = idle(); v.ld_ir = 1'b1; v.cnt_pc = 1'b1;
      seq.push_back(v);
      if (op >= 4'h1 && op <= 4'h9) begin
         seq.push_back(idle());
         v = idle(); v.alu_fs = op; v.ib0 = ri; v.ib1 = rj; v.ib2 = 2'b01;
         v.ld_r = 4'b0001 << ri; v.ld_sr = 1'b1;
         seq.push_back(v);
      end else if (op == 4'hA) begin
         seq.push_back(idle());
         v = idle(); v.ib0 = rj; v.ld_r = 4'b0001 << ri;
         seq.push_back(v);
      end else if (op == 4'hB || op == 4'hC) begin
         v = idle(); v.ib0 = rj; v.ld_mabr = 1'b1; v.ld_maxr = 1'b1; v.cnt_pc = 1'b1;
         seq.push_back(v);
         v = idle(); v.ld_mar = 1'b1; v.ld_ipdr = 1'b1;
         seq.push_back(v);
         v = idle();
         if (op == 4'hB) begin
            v.ld_r = 4'b0001 << ri;
            v.ib2 = (mar == 10'h3FF) ? 2'b11 : 2'b10;
         end else begin
            v.ib0 = ri;
            if (mar == 10'h3FE) v.ld_opdr = 1'b1;
            else v.rw = 1'b0;
         end
         seq.push_back(v);
      end else if (op == 4'hD) begin
         v = idle(); v.ld_mabr = 1'b1; v.ld_maxr = 1'b1; v.cnt_pc = 1'b1;
         seq.push_back(v);
         v = idle(); v.ld_mar = 1'b1;
         seq.push_back(v);
         v = idle(); v.ld_pc = cond_taken(iw[3:0], sr);
         seq.push_back(v);
      end else if (op == 4'hE) begin
         seq.push_back(idle());
`ifdef CJB_CU_HWSTACK_EN
         if (rj == 2'b00) begin
            v = idle(); v.ib0 = ri;
            if (stk.size() < 4) begin v.push = 1'b1; stk.push_back(ri); end
            seq.push_back(v);
         end else if (rj == 2'b01) begin
            v = idle(); v.ipstksel = 1'b1; v.ib2 = 2'b11;
            if (stk.size() > 0) begin
               v.pop = 1'b1; v.ld_r = 4'b0001 << ri;
               void'(stk.pop_back());
            end
            seq.push_back(v);
         end
`endif
      end else if (op == 4'hF) begin
         seq.push_back(idle());
         v = idle(); v.halt = 1'b1;
         repeat (4) seq.push_back(v);
      end else begin
         seq.push_back(idle());
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   always @(negedge Clock) begin
      ovec_t e, got;
      got = {RST_PC, LD_PC, CNT_PC, LD_IR, LD_R3, LD_R2, LD_R1, LD_R0, LD_SR,
             LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR,
             IB0_SEL, IB1_SEL, IB2_SEL, ALU_FS, push, pop, ipstksel, HALT};
      if (push === 1'b1) push_cnt++;
      if (pop === 1'b1) pop_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL outputs cycle=%0d IW=%h got=%h want=%h", cyc, IW, got, e);
         end
         checks++;
         if ((push && pop) || ($countones({LD_R3, LD_R2, LD_R1, LD_R0}) > 1)) begin
            failures++;
            $display("FAIL exclusivity cycle=%0d push=%b pop=%b ld_r=%b want one-hot-or-zero",
                     cyc, push, pop, {LD_R3, LD_R2, LD_R1, LD_R0});
         end
      end
   end

   task automatic wait_drain();
      int budget = 64;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge Clock); #1;
         budget--;
      end
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_instr(input logic [7:0] iw, input logic [3:0] sr,
                            input logic [9:0] mar, input int limit);
      wait_drain();
      @(posedge Clock); #1;
      IW = iw; SR_CNVZ = sr; MARout = mar;
      build(iw, sr, mar);
      for (int i = 0; i < seq.size() && i < limit; i++) exp_q.push_back(seq[i]);
   endtask

   task automatic do_reset(input int n);
      ovec_t r = idle();
      r.rst_pc = 1'b1;
      wait_drain();
      @(posedge Clock); #1;
      Reset = 1'b1; exp_q.push_back(r);
      for (int i = 1; i < n; i++) begin
         @(posedge Clock); #1;
         exp_q.push_back(r);
      end
      @(posedge Clock); #1;
      Reset = 1'b0; exp_q.push_back(r);
      stk.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      int p0, q0, exp_pulses;
      Reset = 1'b1; IW = 8'h00; SR_CNVZ = 4'h0; MARout = 10'h000;

      // hand-computed pins of the model
      build(8'h16, 4'h0, 10'h0);
      chk("pin_add_len", 32'(seq.size()), 32'd3);
      chk("pin_add_exec", 32'({seq[2].alu_fs, seq[2].ib0, seq[2].ib1, seq[2].ib2, seq[2].ld_r, seq[2].ld_sr}),
          32'({4'b0001, 2'b01, 2'b10, 2'b01, 4'b0010, 1'b1}));
      build(8'hD1, 4'b0001, 10'h0);
      chk("pin_jz_taken", 32'(seq[3].ld_pc), 32'd1);
      build(8'hD1, 4'b0000, 10'h0);
      chk("pin_jz_not", 32'(seq[3].ld_pc), 32'd0);
      build(8'hB4, 4'h0, 10'h3FF);
      chk("pin_load_in", 32'({seq[3].ib2, seq[3].ipstksel, seq[3].ld_r}), 32'({2'b11, 1'b0, 4'b0010}));
      build(8'hC4, 4'h0, 10'h3FE);
      chk("pin_store_out", 32'({seq[3].ld_opdr, seq[3].rw}), 32'({1'b1, 1'b1}));
      build(8'hC4, 4'h0, 10'h010);
      chk("pin_store_mem", 32'(seq[3].rw), 32'd0);

      do_reset(2);
      run_instr(8'h16, 4'h0, 10'h0, 99);   // ADD R1,R2
      run_instr(8'h2B, 4'h0, 10'h0, 99);
      run_instr(8'h9C, 4'h0, 10'h0, 99);
      run_instr(8'hA7, 4'h0, 10'h0, 99);   // MOV R1,R3
      run_instr(8'h00, 4'h0, 10'h0, 99);   // NOP
      run_instr(8'hB4, 4'h0, 10'h3FF, 99);
      run_instr(8'hB8, 4'h0, 10'h010, 99);
      run_instr(8'hC4, 4'h0, 10'h3FE, 99);
      run_instr(8'hCC, 4'h0, 10'h010, 99);
      run_instr(8'hD1, 4'b0001, 10'h0, 99);
      run_instr(8'hD1, 4'b0000, 10'h0, 99);
      run_instr(8'hD0, 4'b0000, 10'h0, 99);
      run_instr(8'hD2, 4'b0000, 10'h0, 99);
      run_instr(8'hD3, 4'b1000, 10'h0, 99);
      run_instr(8'hD4, 4'b1000, 10'h0, 99);
      run_instr(8'hD5, 4'b0100, 10'h0, 99);
      run_instr(8'hD6, 4'b0010, 10'h0, 99);
      run_instr(8'hD7, 4'b1111, 10'h0, 99);

      // five pushes then five pops
      wait_drain();
      p0 = push_cnt; q0 = pop_cnt;
      run_instr(8'hE0, 4'h0, 10'h0, 99);
      run_instr(8'hE4, 4'h0, 10'h0, 99);
      run_instr(8'hE8, 4'h0, 10'h0, 99);
      run_instr(8'hEC, 4'h0, 10'h0, 99);
      run_instr(8'hE0, 4'h0, 10'h0, 99);
      run_instr(8'hE1, 4'h0, 10'h0, 99);
      run_instr(8'hE5, 4'h0, 10'h0, 99);
      run_instr(8'hE9, 4'h0, 10'h0, 99);
      run_instr(8'hED, 4'h0, 10'h0, 99);
      run_instr(8'hE1, 4'h0, 10'h0, 99);
      run_instr(8'hE2, 4'h0, 10'h0, 99);
      wait_drain();
`ifdef CJB_CU_HWSTACK_EN
      exp_pulses = 4;
`else
      exp_pulses = 0;
`endif
      chk("push_pulses", 32'(push_cnt - p0), 32'(exp_pulses));
      chk("pop_pulses", 32'(pop_cnt - q0), 32'(exp_pulses));

      // reset clears stack depth
      run_instr(8'hE0, 4'h0, 10'h0, 99);
      run_instr(8'hE4, 4'h0, 10'h0, 99);
      do_reset(1);
      run_instr(8'hE1, 4'h0, 10'h0, 99);

      // reset in the middle of a LOAD
      run_instr(8'hB4, 4'h0, 10'h3FF, 3);
      do_reset(1);
      run_instr(8'h16, 4'h0, 10'h0, 99);

      // halt, then reset out of it
      run_instr(8'hFF, 4'h0, 10'h0, 99);
      do_reset(1);
      run_instr(8'h16, 4'h0, 10'h0, 99);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cjb_risc_hmmiop_cu.md
CJB_RISC_HMMIOP_CU -- requirements
Module: cjb_risc_hmmiop_cu

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named Clock and Reset as in the rest of the codebase.
REQ-002 SHALL expose these ports (clock and reset first):
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- IW  in  8  instruction word from IR.
- SR_CNVZ  in  4  status flags {C,N,V,Z}, bit 3 = C.
- MARout  in  10  data-memory address register.
- RST_PC, LD_PC, CNT_PC, LD_IR  out  1 each  PC and IR controls.
- LD_R0..LD_R3, LD_SR  out  1 each  register-file and status-register loads.
- LD_MABR, LD_MAXR, LD_MAR  out  1 each  address-arithmetic loads.
- RW  out  1  data-memory control; 1 = read, 0 = write.
- LD_IPDR, LD_OPDR  out  1 each  I/O data-register loads.
- IB0_SEL, IB1_SEL, IB2_SEL  out  2 each  bus selects.
- ALU_FS  out  4  ALU function select.
- push, pop, ipstksel  out  1 each  stack controls.
- HALT  out  1  high while in state HLT.

Function
REQ-003 SHALL decode IW as opcode IW[7:4], Ri IW[3:2], Rj IW[1:0].
REQ-004 SHALL use these bus-select encodings:
- IB0_SEL, IB1_SEL: value n selects Rn.
- IB2_SEL: 00 = IB0, 01 = ALU, 10 = DM, 11 = ipstk mux.
- ipstksel: 1 = stack, 0 = IPDR.
REQ-005 SHALL implement a Moore FSM with states RST, FETCH, DEC, EXEC, ADDR, MEM, JMP, HLT.
REQ-006 SHALL drive every output not explicitly asserted in a state to 0, except RW, which SHALL default to 1.
REQ-007 SHALL, in RST, assert RST_PC and go to FETCH.
REQ-008 SHALL, in FETCH, assert LD_IR and CNT_PC and go to DEC.
REQ-009 SHALL treat opcodes 0001-1001 as ALU ops taking 3 cycles (FETCH, DEC, EXEC); in EXEC it SHALL set ALU_FS = opcode, IB0_SEL = Ri, IB1_SEL = Rj, IB2_SEL = 01, and assert LD_Ri and LD_SR.
REQ-010 SHALL, for opcode 1010 (MOV), in EXEC set IB0_SEL = Rj and IB2_SEL = 00, assert LD_Ri, and leave LD_SR low.
REQ-011 SHALL treat 1011 (LOAD Ri,[base+Rj]) and 1100 (STORE) as two-word instructions; in DEC it SHALL set IB0_SEL = Rj and IB2_SEL = 00 and assert LD_MABR, LD_MAXR and CNT_PC.
REQ-012 SHALL, for LOAD/STORE, in ADDR assert LD_MAR and LD_IPDR, then go to MEM.
REQ-013 SHALL, for LOAD in MEM, assert LD_Ri with IB2_SEL = 10, except when MARout = 0x3FF, where it SHALL use IB2_SEL = 11 with ipstksel = 0.
REQ-014 SHALL, for STORE in MEM, set IB0_SEL = Ri and IB2_SEL = 00 and drive RW = 0, except when MARout = 0x3FE, where it SHALL assert LD_OPDR and keep RW = 1.
REQ-015 SHALL treat 1101 (JUMP cc) as a two-word instruction:
- DEC: assert LD_MABR, LD_MAXR, CNT_PC.
- ADDR: assert LD_MAR.
- JMP: assert LD_PC only if the condition is true.
REQ-016 SHALL evaluate JUMP conditions from IW[3:0]: 0000 always, 0001 Z, 0010 !Z, 0011 C, 0100 !C, 0101 N, 0110 V; all other codes are never taken.
REQ-017 SHALL treat opcode 0000 as NOP, returning from DEC to FETCH.
REQ-018 SHALL treat 1111 as HALT: enter HLT, hold HALT = 1 with all loads low, and leave only on Reset.
REQ-019 SHALL keep an internal stack depth counter 0..4, reset to 0.
REQ-020 SHALL, for 1110 with Rj = 00 (PUSH Ri), in EXEC set IB0_SEL = Ri and IB2_SEL = 00 and assert push if depth < 4 (then depth +1); when depth = 4 it SHALL suppress push and leave depth unchanged.
REQ-021 SHALL, for 1110 with Rj = 01 (POP Ri), in EXEC set ipstksel = 1 and IB2_SEL = 11 and assert pop and LD_Ri if depth > 0 (then depth -1); when depth = 0 it SHALL suppress both, leaving Ri unchanged.
REQ-022 SHALL treat 1110 with Rj = 1x as a NOP.
REQ-023 SHALL never assert push and pop in the same cycle, and never assert more than one LD_Rn per cycle.

Reset
REQ-024 SHALL, on a cycle with Reset = 1, force the state to RST and depth to 0, regardless of current state, including mid-LOAD/STORE and HLT.
REQ-025 SHALL, while Reset = 1, hold every output at its default, with RW = 1, HALT = 0 and RST_PC = 1.

Configuration
REQ-026 SHALL use macro CJB_CU_HWSTACK_EN: when defined, opcode 1110 behaves per REQ-020..REQ-022; when undefined, 1110 decodes as NOP, push, pop and ipstksel are tied to 0, and the depth counter is absent.

Verification
REQ-027 SHALL pass these directed scenarios:
- Reset held 2 cycles, then released -> RST_PC = 1 during reset and for one cycle after; LD_IR = 1 on the 2nd cycle after release.
- IW = 0x16 (ADD R1,R2) -> in EXEC: ALU_FS = 0001, IB0_SEL = 01, IB1_SEL = 10, IB2_SEL = 01, LD_R1 = 1, LD_SR = 1; FETCH follows.
- LOAD with MARout = 0x3FF -> in MEM: IB2_SEL = 11, ipstksel = 0, LD_Ri = 1. STORE with MARout = 0x3FE -> LD_OPDR = 1, RW = 1. STORE with MARout = 0x010 -> RW = 0.
- IW = 0xD1 with SR_CNVZ = 0001 -> LD_PC = 1 in JMP; with SR_CNVZ = 0000 -> LD_PC = 0 and FETCH follows.
- 5 PUSHes then 5 POPs -> push pulses 4 times and pop pulses 4 times; the 5th of each is suppressed; with the macro undefined, push and pop never assert.
- IW = 0xFF -> HALT = 1 and held; Reset then returns the FSM to RST with HALT = 0.
